banked_memory: RTL and testbench

Parametrised multi-port, multi-bank on-chip SRAM model that replaces the fixed two-port IMEM/DMEM memory. Each of `NUM_PORTS` requesters issues valid/ready requests. Requests are word-interleaved across `NUM_BANKS` single-port banks, and same-cycle bank conflicts are resolved by a per-bank round-robin arbiter. The block sits behind the core's fetch and load/store units, with port 0 conventionally used for instruction fetch, and returns read data with a fixed one-cycle latency after acceptance.

---
 rtl/CPU_profile.sv | 26 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/banked_memory.sv | 150 +++++++++++++++
 tb/tb_banked_memory.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/CPU_profile.sv
// ---------------------------------------------------------------------------
// CPU_profile
// Shared core profile: machine word width, byte-to-word address shift,
// memory size in words, and the request bundle used by memory requesters.
// No ports (package).
// ---------------------------------------------------------------------------
package CPU_profile;

   localparam int XLEN       = 32;
   localparam int ADDR_SHIFT = 2;
   localparam int MEM_SIZE   = 256;

   // One memory request as seen by a requester port
   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic              wen;
      logic [XLEN/8-1:0] wstrb;
      logic [XLEN-1:0]   wdata;
   } mem_req_t;

   // Byte address to word index; low ADDR_SHIFT bits are dropped
   function automatic logic [XLEN-1:0] wordIndex(input logic [XLEN-1:0] addr);
      return addr >> ADDR_SHIFT;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (pointer returns to 0)
//   req    in  [N] request vector
//   gnt    out [N] one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Scan offsets from the far end back to the pointer so that the
   // requester closest to ptr is the last (winning) assignment.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      for (int i = N - 1; i >= 0; i--) begin
         for (int j = 0; j < N; j++) begin
            if ((j == ((int'(ptr_q) + i) % N)) && req[j]) begin
               gnt    = '0;
               gnt[j] = 1'b1;
               ptr_d  = PTR_W'((j + 1) % N);
            end
         end
      end
   end

   // Pointer register; only moves when a grant is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/banked_memory.sv
// ---------------------------------------------------------------------------
// banked_memory
// Multi-port, word-interleaved, multi-bank SRAM model. Each bank is
// single-ported and arbitrated round-robin among the requester ports.
// Read data returns one cycle after acceptance.
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   req_valid  in  [NUM_PORTS] request present
//   req_ready  out [NUM_PORTS] request accepted this cycle (combinational)
//   req_addr   in  [NUM_PORTS][XLEN] byte address
//   req_wen    in  [NUM_PORTS] 1 = write, 0 = read
//   req_wstrb  in  [NUM_PORTS][DATA_W/8] write byte enables
//   req_wdata  in  [NUM_PORTS][DATA_W] write data
//   rsp_valid  out [NUM_PORTS] response for last cycle's accepted request
//   rsp_rdata  out [NUM_PORTS][DATA_W] read data (held between reads)
// ---------------------------------------------------------------------------
module banked_memory
   import CPU_profile::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int NUM_BANKS   = 4,
   parameter int DEPTH_WORDS = MEM_SIZE,
   parameter int DATA_W      = XLEN
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_PORTS-1:0]                 req_valid,
   output logic [NUM_PORTS-1:0]                 req_ready,
   input  logic [NUM_PORTS-1:0][XLEN-1:0]       req_addr,
   input  logic [NUM_PORTS-1:0]                 req_wen,
   input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   req_wstrb,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]                 rsp_valid,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]     rsp_rdata
);

   localparam int ROWS   = DEPTH_WORDS / NUM_BANKS;
   localparam int LANES  = DATA_W / 8;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [NUM_PORTS-1:0][BANK_W-1:0]    portBank;
   logic [NUM_PORTS-1:0][ROW_W-1:0]     portRow;
   logic [NUM_BANKS-1:0][NUM_PORTS-1:0] gntAll;
   logic [NUM_BANKS-1:0][DATA_W-1:0]    bankRdata;

   logic [NUM_PORTS-1:0]              rspValid_q;
   logic [NUM_PORTS-1:0]              rspValid_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  rspRdata_q;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  rspRdata_d;

   // Address decode per port: low word bits pick the bank, next bits pick
   // the row; anything above is dropped so addresses wrap.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [XLEN-1:0] portWord;
      assign portWord    = wordIndex(req_addr[p]);
      assign portBank[p] = BANK_W'(portWord % NUM_BANKS);
      assign portRow[p]  = ROW_W'((portWord / NUM_BANKS) % ROWS);
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [NUM_PORTS-1:0] bankReq;
      logic [ROW_W-1:0]     selRow;
      logic                 selWrite;
      logic [LANES-1:0]     selStrb;
      logic [DATA_W-1:0]    selWdata;
      logic [DATA_W-1:0]    mem [ROWS];

      // Requests are masked while in reset so nothing is granted or
      // written during that time and the pointers stay at 0.
      always_comb begin
         bankReq = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            bankReq[p] = rst_n && req_valid[p] && (portBank[p] == BANK_W'(b));
         end
      end

      rr_arbiter #(
         .N(NUM_PORTS)
      ) u_arb (
         .clk  (clk),
         .rst_n(rst_n),
         .req  (bankReq),
         .gnt  (gntAll[b])
      );

      // Steer the single granted port's fields onto the bank
      always_comb begin
         selRow   = '0;
         selWrite = 1'b0;
         selStrb  = '0;
         selWdata = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (gntAll[b][p]) begin
               selRow   = portRow[p];
               selWrite = req_wen[p];
               selStrb  = req_wstrb[p];
               selWdata = req_wdata[p];
            end
         end
      end

      // Storage is deliberately not reset so contents survive rst_n
      always_ff @(posedge clk) begin
         if (selWrite) begin
            for (int l = 0; l < LANES; l++) begin
               if (selStrb[l]) begin
                  mem[selRow][l*8 +: 8] <= selWdata[l*8 +: 8];
               end
            end
         end
      end

      assign bankRdata[b] = mem[selRow];
   end

   // A port is ready when whichever bank it targets granted it
   always_comb begin
      req_ready = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         req_ready = req_ready | gntAll[b];
      end
   end

   // Response stage: valid for every accepted request, data only on reads
   always_comb begin
      rspValid_d = req_ready;
      rspRdata_d = rspRdata_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (req_ready[p] && !req_wen[p]) begin
            rspRdata_d[p] = bankRdata[portBank[p]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rspValid_q <= '0;
         rspRdata_q <= '0;
      end else begin
         rspValid_q <= rspValid_d;
         rspRdata_q <= rspRdata_d;
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_banked_memory.sv
// ---------------------------------------------------------------------------
// tb_banked_memory
// Directed bench for banked_memory (2 ports, 4 banks, 256 words).
// ---------------------------------------------------------------------------
module tb_banked_memory;

   localparam int NP    = 2;
   localparam int NB    = 4;
   localparam int DEPTH = 256;
   localparam int DW    = 32;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [NP-1:0]             reqValid;
   logic [NP-1:0]             reqReady;
   logic [NP-1:0][31:0]       reqAddr;
   logic [NP-1:0]             reqWen;
   logic [NP-1:0][3:0]        reqWstrb;
   logic [NP-1:0][DW-1:0]     reqWdata;
   logic [NP-1:0]             rspValid;
   logic [NP-1:0][DW-1:0]     rspRdata;

   int checks   = 0;
   int failures = 0;
   int rspCount0;
   int rspCount1;
   logic [1:0] expRdy;

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   banked_memory #(
      .NUM_PORTS  (NP),
      .NUM_BANKS  (NB),
      .DEPTH_WORDS(DEPTH),
      .DATA_W     (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(reqValid),
      .req_ready(reqReady),
      .req_addr (reqAddr),
      .req_wen  (reqWen),
      .req_wstrb(reqWstrb),
      .req_wdata(reqWdata),
      .rsp_valid(rspValid),
      .rsp_rdata(rspRdata)
   );

   // Drive one port's request fields
   task automatic applyStimulus(input int port, input logic valid, input logic [31:0] addr,
                                input logic wen, input logic [3:0] strb, input logic [31:0] data);
      reqValid[port] = valid;
      reqAddr[port]  = addr;
      reqWen[port]   = wen;
      reqWstrb[port] = strb;
      reqWdata[port] = data;
   endtask

   // Compare one observed value against the expected one
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Directed sequence; inputs change on negedge, outputs sampled #1 later
   // or #1 after the rising edge.
   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // Random traffic while held in reset
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         applyStimulus(0, 1'b1, $urandom_range(0, 255) << 2, 1'($urandom), 4'hF, $urandom);
         applyStimulus(1, 1'b1, $urandom_range(0, 255) << 2, 1'($urandom), 4'hF, $urandom);
         #1 checkOutput("reset_ready", 32'(reqReady), 32'h0);
         @(posedge clk); #1;
         checkOutput("reset_rsp_valid", 32'(rspValid), 32'h0);
      end
      checkOutput("reset_rdata0", rspRdata[0], 32'h0);
      checkOutput("reset_rdata1", rspRdata[1], 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // No conflict: p0 reads 0x0 (bank0), p1 writes 0x4 (bank1)
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h4, 1'b1, 4'hF, 32'hDEADBEEF);
      #1 checkOutput("nc_ready", 32'(reqReady), 32'h3);
      @(posedge clk); #1;
      checkOutput("nc_rsp_valid", 32'(rspValid), 32'h3);
      checkOutput("nc_write_rdata_held", rspRdata[1], 32'h0);

      // Read back 0x4 the following cycle
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      #1 checkOutput("rb_ready", 32'(reqReady), 32'h1);
      @(posedge clk); #1;
      checkOutput("rb_rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("rb_rdata", rspRdata[0], 32'hDEADBEEF);

      // Byte strobes on 0x8
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h8, 1'b1, 4'hF, 32'h11223344);
      @(posedge clk); #1;
      checkOutput("wr_rdata_held", rspRdata[0], 32'hDEADBEEF);
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h8, 1'b1, 4'h6, 32'hAABBCCDD);
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
      @(posedge clk); #1;
      checkOutput("strb_rdata", rspRdata[0], 32'h11BBCC44);

      // Seed bank0 rows via p1 (leaves bank0 pointer at 0)
      @(negedge clk);
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h0, 1'b1, 4'hF, 32'hA0A0A0A0);
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'h10, 1'b1, 4'hF, 32'hB1B1B1B1);

      // Conflict on bank0 for four cycles: grants alternate p0, p1
      rspCount0 = 0;
      rspCount1 = 0;
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         expRdy = (c % 2 == 0) ? 2'b01 : 2'b10;
         #1 checkOutput("cf_ready", 32'(reqReady), 32'(expRdy));
         @(posedge clk); #1;
         checkOutput("cf_rsp_valid", 32'(rspValid), 32'(expRdy));
         if (rspValid[0]) rspCount0++;
         if (rspValid[1]) rspCount1++;
         if (c % 2 == 0) checkOutput("cf_rdata0", rspRdata[0], 32'hA0A0A0A0);
         else            checkOutput("cf_rdata1", rspRdata[1], 32'hB1B1B1B1);
         @(negedge clk);
      end
      checkOutput("cf_count0", 32'(rspCount0), 32'd2);
      checkOutput("cf_count1", 32'(rspCount1), 32'd2);

      // Wrap: byte address DEPTH*4 aliases word 0
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'(DEPTH * 4), 1'b1, 4'hF, 32'h5A5A5A5A);
      #1 checkOutput("wrap_ready", 32'(reqReady), 32'h2);
      @(negedge clk);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      @(posedge clk); #1;
      checkOutput("wrap_rdata", rspRdata[0], 32'h5A5A5A5A);

      // Reset while a read is being accepted: response must never appear
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
      #1 checkOutput("mr_ready_before", 32'(reqReady), 32'h1);
      #1 rst_n = 1'b0;
      applyStimulus(1, 1'b1, 32'h8, 1'b1, 4'hF, 32'hFFFFFFFF);
      #1 checkOutput("mr_ready_in_reset", 32'(reqReady), 32'h0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checkOutput("mr_rsp_valid", 32'(rspValid), 32'h0);
      end
      checkOutput("mr_rdata_cleared", rspRdata[0], 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // Memory retained across reset (and the write during reset dropped)
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
      #1 checkOutput("ar_ready", 32'(reqReady), 32'h3);
      @(posedge clk); #1;
      checkOutput("ar_rdata0", rspRdata[0], 32'h11BBCC44);
      checkOutput("ar_rdata1", rspRdata[1], 32'hDEADBEEF);

      // Bank0 pointer was 1 before reset; reset returns it to 0
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
      #1 checkOutput("ar_ptr_ready", 32'(reqReady), 32'h1);
      @(posedge clk); #1;
      checkOutput("ar_ptr_rdata0", rspRdata[0], 32'h5A5A5A5A);

      @(negedge clk);
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
